// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 3-input function through its 8 rows,
// samples its output per row and compares the captured word.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   start          sweep request, seen only in IDLE
//   fn_out         function output, may be asynchronous
//   in1/in2/in3    function inputs, row index MSB..LSB
//   busy, done     sweep in progress / one-cycle completion pulse
//   table_out      captured word, row r at bit 7-r
//   match          table_out == EXPECTED and no unstable rows
//   mismatch_mask  table_out ^ EXPECTED
//   unstable_mask  rows whose samples disagreed
module truth_table_sweeper #(
    parameter int          SETTLE_CYCLES = 4,
    parameter int          N_SAMPLES     = 2,
    parameter logic [7:0]  EXPECTED      = 8'hD7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       fn_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match,
    output logic [7:0] mismatch_mask,
    output logic [7:0] unstable_mask
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(N_SAMPLES - 1);

    state_t     state_q;
    logic       sync1_q;
    logic       sync2_q;
    logic [2:0] row_q;
    logic [2:0] in_q;
    logic [7:0] settle_cnt_q;
    logic [3:0] sample_cnt_q;
    logic       ref_q;
    logic [7:0] work_q;
    logic [7:0] work_d;
    logic [7:0] unst_work_q;
    logic [7:0] unst_work_d;
    logic [7:0] table_q;
    logic [7:0] unst_q;
    logic [7:0] mism_q;
    logic       match_q;
    logic       busy_q;
    logic       done_q;

    logic sample_first;
    logic sample_last;

    assign sample_first = (sample_cnt_q == 4'd0);
    assign sample_last  = (sample_cnt_q == SAMPLE_LAST);

    // Working results including this cycle's sample; row r lands at
    // bit 7-r, which for a 3-bit index is simply ~r.
    always_comb begin
        work_d      = work_q;
        unst_work_d = unst_work_q;
        if (state_q == SAMPLE) begin
            if (sample_last) begin
                work_d[~row_q] = sync2_q;
            end
            if (!sample_first && (sync2_q != ref_q)) begin
                unst_work_d[~row_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            row_q        <= 3'd0;
            in_q         <= 3'd0;
            settle_cnt_q <= 8'd0;
            sample_cnt_q <= 4'd0;
            ref_q        <= 1'b0;
            work_q       <= 8'd0;
            unst_work_q  <= 8'd0;
            table_q      <= 8'd0;
            unst_q       <= 8'd0;
            mism_q       <= 8'd0;
            match_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sync1_q <= fn_out;
            sync2_q <= sync1_q;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= SETTLE;
                        row_q        <= 3'd0;
                        in_q         <= 3'd0;
                        settle_cnt_q <= 8'd0;
                        work_q       <= 8'd0;
                        unst_work_q  <= 8'd0;
                        busy_q       <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q      <= SAMPLE;
                        sample_cnt_q <= 4'd0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end
                SAMPLE: begin
                    work_q      <= work_d;
                    unst_work_q <= unst_work_d;
                    if (sample_first) begin
                        ref_q <= sync2_q;
                    end
                    if (!sample_last) begin
                        sample_cnt_q <= sample_cnt_q + 4'd1;
                    end else if (row_q == 3'd7) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        in_q    <= 3'd0;
                        table_q <= work_d;
                        unst_q  <= unst_work_d;
                        mism_q  <= work_d ^ EXPECTED;
                        match_q <= (work_d == EXPECTED) &&
                                   (unst_work_d == 8'd0);
                    end else begin
                        // Next row's inputs launch on this same edge.
                        state_q      <= SETTLE;
                        row_q        <= row_q + 3'd1;
                        in_q         <= row_q + 3'd1;
                        settle_cnt_q <= 8'd0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in1           = in_q[2];
    assign in2           = in_q[1];
    assign in3           = in_q[0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign table_out     = table_q;
    assign match         = match_q;
    assign mismatch_mask = mism_q;
    assign unstable_mask = unst_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized sweeps of three sweeper instances
// (4/2, 1/1, 3/1 settle/sample) against a cycle-schedule reference.
module tb_truth_table_sweeper;

    localparam int NI = 3;

    function automatic int st_of(input int i);
        return (i == 1) ? 1 : (i == 2) ? 3 : 4;
    endfunction

    function automatic int ns_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_r [NI];
    logic       inv_r   [NI];
    logic [7:0] fnw     [NI];
    logic       fn_w    [NI];
    logic       in1_w   [NI];
    logic       in2_w   [NI];
    logic       in3_w   [NI];
    logic       busy_w  [NI];
    logic       done_w  [NI];
    logic       match_w [NI];
    logic [7:0] table_w [NI];
    logic [7:0] mism_w  [NI];
    logic [7:0] unst_w  [NI];

    int checks = 0;
    int errors = 0;
    bit gl [64];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        // Function under control: word bit 7-row, optionally inverted.
        assign fn_w[i] = fnw[i][~{in1_w[i], in2_w[i], in3_w[i]}]
                         ^ inv_r[i];
        truth_table_sweeper #(
            .SETTLE_CYCLES(st_of(i)),
            .N_SAMPLES    (ns_of(i)),
            .EXPECTED     (8'hD7)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start_r[i]),
            .fn_out       (fn_w[i]),
            .in1          (in1_w[i]),
            .in2          (in2_w[i]),
            .in3          (in3_w[i]),
            .busy         (busy_w[i]),
            .done         (done_w[i]),
            .table_out    (table_w[i]),
            .match        (match_w[i]),
            .mismatch_mask(mism_w[i]),
            .unstable_mask(unst_w[i])
        );
    end

    // Reference: busy cycle c presents row c/(s+n); a sample taken at
    // the end of cycle c sees the function as it was during cycle c-2.
    function automatic void model(input logic [7:0] fw, input int s,
                                  input int n, output logic [7:0] tbl,
                                  output logic [7:0] un);
        int   p;
        int   c;
        int   row;
        logic smp;
        logic first;
        p     = s + n;
        tbl   = 8'd0;
        un    = 8'd0;
        smp   = 1'b0;
        first = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < n; k++) begin
                c   = r * p + s + k - 2;
                row = (c < 0) ? 0 : c / p;
                smp = fw[7 - row] ^ ((c >= 0) ? gl[c] : 1'b0);
                if (k == 0) first = smp;
                else if (smp != first) un[7 - r] = 1'b1;
            end
            tbl[7 - r] = smp;
        end
    endfunction

    task automatic clear_gl();
        for (int k = 0; k < 64; k++) gl[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic sweep(input int i, input bit hold, input int poke,
                         output int bcnt, output int dcnt,
                         output logic dn_end, output logic bz_end);
        int total;
        total = 8 * (st_of(i) + ns_of(i));
        bcnt = 0;
        dcnt = 0;
        start_r[i] = 1'b1;
        @(posedge clk);
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            start_r[i] = hold || (c == poke);
            inv_r[i]   = gl[c];
            if (busy_w[i]) bcnt++;
            if (done_w[i]) dcnt++;
        end
        @(negedge clk);
        inv_r[i] = 1'b0;
        dn_end = done_w[i];
        bz_end = busy_w[i];
    endtask

    task automatic test_reset();
        idle(2);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({busy_w[i], done_w[i], in1_w[i], in2_w[i], in3_w[i],
                 match_w[i], table_w[i], mism_w[i], unst_w[i]} !== '0) begin
                errors++;
                $display("FAIL reset inst%0d: busy=%b done=%b tbl=%h mm=%h un=%h want all 0",
                         i, busy_w[i], done_w[i], table_w[i], mism_w[i], unst_w[i]);
            end
        end
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_basic();
        int bc, dc;
        logic dn, bz;
        logic [7:0] et, eu;
        fnw[0] = 8'hD7;
        clear_gl();
        sweep(0, 1'b0, -1, bc, dc, dn, bz);
        model(fnw[0], 4, 2, et, eu);
        checks++;
        if (bc !== 8 * (4 + 2)) begin
            errors++;
            $display("FAIL basic busy_cycles: got %0d want %0d", bc, 48);
        end
        checks++;
        if (dc !== 0 || dn !== 1'b1 || bz !== 1'b0) begin
            errors++;
            $display("FAIL basic done: early=%0d done=%b busy=%b want 0 1 0", dc, dn, bz);
        end
        checks++;
        if (table_w[0] !== et || unst_w[0] !== eu) begin
            errors++;
            $display("FAIL basic table: got %h/%h want %h/%h", table_w[0], unst_w[0], et, eu);
        end
        checks++;
        if (mism_w[0] !== (et ^ 8'hD7) || match_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic match: got mm=%h m=%b want %h 1", mism_w[0], match_w[0], et ^ 8'hD7);
        end
        @(negedge clk);
        checks++;
        if (done_w[0] !== 1'b0 || table_w[0] !== et) begin
            errors++;
            $display("FAIL basic after_done: done=%b tbl=%h want 0 %h", done_w[0], table_w[0], et);
        end
    endtask

    task automatic test_functions();
        int bc, dc;
        logic dn, bz;
        logic [7:0] et, eu, w;
        clear_gl();
        for (int t = 0; t < 6; t++) begin
            w = (t == 0) ? 8'h00 : (t == 1) ? 8'hEB : 8'($urandom_range(0, 255));
            fnw[0] = w;
            idle(3);
            sweep(0, 1'b0, -1, bc, dc, dn, bz);
            model(w, 4, 2, et, eu);
            checks++;
            if (table_w[0] !== et || unst_w[0] !== eu || mism_w[0] !== (et ^ 8'hD7)
                || match_w[0] !== ((et == 8'hD7) && (eu == 8'h00))) begin
                errors++;
                $display("FAIL func fn=%h: got tbl=%h un=%h mm=%h m=%b want %h %h %h",
                         w, table_w[0], unst_w[0], mism_w[0], match_w[0], et, eu, et ^ 8'hD7);
            end
        end
    endtask

    task automatic test_glitch();
        int bc, dc;
        logic dn, bz;
        logic [7:0] et, eu;
        fnw[0] = 8'hD7;
        idle(3);
        clear_gl();
        // Only the second sample of row 011 sees the inverted value.
        gl[21] = 1'b1;
        sweep(0, 1'b0, -1, bc, dc, dn, bz);
        model(fnw[0], 4, 2, et, eu);
        checks++;
        if (table_w[0] !== et || unst_w[0] !== eu || eu !== 8'h10 || match_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch row3: got tbl=%h un=%h m=%b want %h %h 0",
                     table_w[0], unst_w[0], match_w[0], et, eu);
        end
        for (int t = 0; t < 4; t++) begin
            clear_gl();
            fnw[0] = 8'($urandom_range(0, 255));
            idle(3);
            for (int k = 0; k < 3; k++) gl[$urandom_range(0, 45)] = 1'b1;
            sweep(0, 1'b0, -1, bc, dc, dn, bz);
            model(fnw[0], 4, 2, et, eu);
            checks++;
            if (table_w[0] !== et || unst_w[0] !== eu
                || match_w[0] !== ((et == 8'hD7) && (eu == 8'h00))) begin
                errors++;
                $display("FAIL glitch rand fn=%h: got tbl=%h un=%h m=%b want %h %h",
                         fnw[0], table_w[0], unst_w[0], match_w[0], et, eu);
            end
        end
        clear_gl();
    endtask

    task automatic test_abort();
        int bc, dc, bad;
        logic dn, bz;
        logic [7:0] et, eu;
        fnw[0] = 8'hD7;
        idle(3);
        start_r[0] = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            start_r[0] = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_w[0], done_w[0], in1_w[0], in2_w[0], in3_w[0],
             match_w[0], table_w[0], mism_w[0], unst_w[0]} !== '0) begin
            errors++;
            $display("FAIL abort outputs: busy=%b in=%b%b%b tbl=%h un=%h m=%b want all 0",
                     busy_w[0], in1_w[0], in2_w[0], in3_w[0], table_w[0], unst_w[0], match_w[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (busy_w[0] || done_w[0]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort idle: got %0d busy/done cycles want 0", bad);
        end
        sweep(0, 1'b0, -1, bc, dc, dn, bz);
        model(fnw[0], 4, 2, et, eu);
        checks++;
        if (bc !== 48 || dn !== 1'b1 || table_w[0] !== et || match_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort resweep: busy=%0d done=%b tbl=%h m=%b want 48 1 %h 1",
                     bc, dn, table_w[0], match_w[0], et);
        end
    endtask

    task automatic test_back_to_back();
        int bc, dc, extra;
        logic dn, bz;
        logic [7:0] et, eu;
        fnw[0] = 8'hD7;
        idle(3);
        model(fnw[0], 4, 2, et, eu);
        sweep(0, 1'b0, 10, bc, dc, dn, bz);
        extra = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_w[0] || busy_w[0]) extra++;
        end
        checks++;
        if (bc !== 48 || dc !== 0 || dn !== 1'b1 || extra !== 0) begin
            errors++;
            $display("FAIL ignore_start: busy=%0d early=%0d done=%b extra=%0d want 48 0 1 0",
                     bc, dc, dn, extra);
        end
        sweep(0, 1'b1, -1, bc, dc, dn, bz);
        checks++;
        if (dn !== 1'b1 || bc !== 48) begin
            errors++;
            $display("FAIL hold first: done=%b busy=%0d want 1 48", dn, bc);
        end
        @(negedge clk);
        checks++;
        if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold gap: busy=%b done=%b want 0 0", busy_w[0], done_w[0]);
        end
        sweep(0, 1'b0, -1, bc, dc, dn, bz);
        checks++;
        if (bc !== 48 || dn !== 1'b1 || table_w[0] !== et || match_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold second: busy=%0d done=%b tbl=%h m=%b want 48 1 %h 1",
                     bc, dn, table_w[0], match_w[0], et);
        end
    endtask

    task automatic test_settle();
        int bc, dc;
        logic dn, bz;
        logic [7:0] et, eu;
        clear_gl();
        fnw[1] = 8'hD7;
        sweep(1, 1'b0, -1, bc, dc, dn, bz);
        model(fnw[1], 1, 1, et, eu);
        checks++;
        if (table_w[1] !== et || table_w[1] === 8'hD7 || bc !== 16 || match_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL settle1: got tbl=%h busy=%0d m=%b want %h 16 0",
                     table_w[1], bc, match_w[1], et);
        end
        fnw[2] = 8'hD7;
        sweep(2, 1'b0, -1, bc, dc, dn, bz);
        model(fnw[2], 3, 1, et, eu);
        checks++;
        if (table_w[2] !== et || bc !== 32 || match_w[2] !== 1'b1) begin
            errors++;
            $display("FAIL settle3: got tbl=%h busy=%0d m=%b want %h 32 1",
                     table_w[2], bc, match_w[2], et);
        end
        for (int t = 0; t < 3; t++) begin
            fnw[1] = 8'($urandom_range(0, 255));
            idle(3);
            sweep(1, 1'b0, -1, bc, dc, dn, bz);
            model(fnw[1], 1, 1, et, eu);
            checks++;
            if (table_w[1] !== et || unst_w[1] !== eu) begin
                errors++;
                $display("FAIL settle1 rand fn=%h: got %h/%h want %h/%h",
                         fnw[1], table_w[1], unst_w[1], et, eu);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            start_r[i] = 1'b0;
            inv_r[i]   = 1'b0;
            fnw[i]     = 8'hD7;
        end
        clear_gl();
        test_reset();
        test_basic();
        test_functions();
        test_glitch();
        test_abort();
        test_back_to_back();
        test_settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
